// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, issues one outstanding word read at a time,
// and buffers returned instructions with their PC in a small FIFO for the decode stage.
module fetch_queue #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   PC_RESET = '0,
    parameter int                DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_mem_req,
    output logic [XLEN-1:0]          o_mem_addr,
    input  logic                     i_mem_ready,
    input  logic [XLEN-1:0]          i_mem_data,
    output logic                     o_valid,
    output logic [XLEN-1:0]          o_inst,
    output logic [XLEN-1:0]          o_pc,
    input  logic                     i_ready,
    input  logic                     i_redirect,
    input  logic [XLEN-1:0]          i_redirect_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISC
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [XLEN-1:0]   r_fetchPc;
    logic [XLEN-1:0]   w_fetchPcNext;
    logic [XLEN-1:0]   r_reqAddr;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [XLEN-1:0]   r_instMem [DEPTH];
    logic [XLEN-1:0]   r_pcMem   [DEPTH];

    logic [XLEN-1:0]   w_redirectPc;
    logic [XLEN-1:0]   w_pcPlus4;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_countAfter;
    logic              w_holdAddr;

    assign w_redirectPc = i_redirect_pc & ~XLEN'(3);
    assign w_pcPlus4    = r_fetchPc + XLEN'(4);
    assign w_push       = (r_state == S_REQ) && i_mem_ready && !i_redirect;
    assign w_pop        = (r_count != '0) && i_ready && !i_redirect;
    assign w_countAfter = r_count + CW'(w_push) - CW'(w_pop);
    // The address presented to memory must not move while a read is still pending.
    assign w_holdAddr   = (r_state != S_IDLE) && !i_mem_ready;

    always_comb begin
        w_stateNext   = r_state;
        w_fetchPcNext = r_fetchPc;
        case (r_state)
            S_IDLE: begin
                if (i_redirect) begin
                    w_fetchPcNext = w_redirectPc;
                    w_stateNext   = S_REQ;
                end else if (r_count < CW'(DEPTH)) begin
                    w_stateNext   = S_REQ;
                end
            end
            S_REQ: begin
                if (!i_mem_ready) begin
                    if (i_redirect) begin
                        w_fetchPcNext = w_redirectPc;
                        w_stateNext   = S_DISC;
                    end
                end else if (i_redirect) begin
                    w_fetchPcNext = w_redirectPc;
                    w_stateNext   = S_REQ;
                end else begin
                    w_fetchPcNext = w_pcPlus4;
                    w_stateNext   = (w_countAfter < CW'(DEPTH)) ? S_REQ : S_IDLE;
                end
            end
            S_DISC: begin
                if (i_redirect) begin
                    w_fetchPcNext = w_redirectPc;
                end
                if (i_mem_ready) begin
                    w_stateNext = S_REQ;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_fetchPc <= PC_RESET;
            r_reqAddr <= PC_RESET;
        end else begin
            r_state   <= w_stateNext;
            r_fetchPc <= w_fetchPcNext;
            if (!w_holdAddr) begin
                r_reqAddr <= w_fetchPcNext;
            end
        end
    end

    // A redirect empties the queue outright, overriding any push or pop in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instMem[i] <= '0;
                r_pcMem[i]   <= '0;
            end
        end else if (i_redirect) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_instMem[r_wrPtr] <= i_mem_data;
                r_pcMem[r_wrPtr]   <= r_fetchPc;
                r_wrPtr            <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count <= w_countAfter;
        end
    end

    assign o_mem_req  = (r_state != S_IDLE);
    assign o_mem_addr = r_reqAddr;
    assign o_valid    = (r_count != '0);
    assign o_inst     = r_instMem[r_rdPtr];
    assign o_pc       = r_pcMem[r_rdPtr];
    assign o_count    = r_count;

endmodule
